// File: rtl/count_binary_led_writer.sv
// Avalon-MM master that writes an incrementing binary count to the LED PIO on each
// prescaler tick and, when VERIFY is set, reads it back to flag corruption.
module count_binary_led_writer #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned TARGET_ADDR = 0,
  parameter bit          VERIFY      = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               err_clear,
  output logic [1:0]         avm_address,
  output logic               avm_write,
  output logic               avm_read,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_waitrequest,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               error,
  output logic               overrun
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [COUNT_W-1:0]   next_q, next_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic                 read_q, read_d;
  logic                 busy_q, busy_d;
  logic                 pend_q, pend_d;
  logic                 error_q, error_d;
  logic                 overrun_q, overrun_d;

  logic                 tick_s;
  logic                 req_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic                 consume_s;
  logic                 mism_s;
  logic [COUNT_W-1:0]   next_inc_s;
  logic                 rd_unused_s;

  // Upper readdata bits are deliberately ignored by the compare.
  assign rd_unused_s = ^avm_readdata;

  // Prescaler, transaction FSM and sticky status next-state logic.
  always_comb begin
    tick_s     = 1'b0;
    presc_d    = '0;
    state_d    = state_q;
    next_d     = next_q;
    count_d    = count_q;
    wdata_d    = wdata_q;
    consume_s  = 1'b0;
    mism_s     = 1'b0;
    next_inc_s = next_q + COUNT_W'(1);

    if (enable) begin
      if (presc_q == PRESC_LAST) begin
        tick_s  = 1'b1;
        presc_d = '0;
      end else begin
        tick_s  = 1'b0;
        presc_d = presc_q + PRESC_W'(1);
      end
    end else begin
      presc_d = '0;
    end

    req_s    = tick_s | (pend_q & enable);
    wr_acc_s = (state_q == S_WR) & ~avm_waitrequest;
    rd_acc_s = (state_q == S_RD) & ~avm_waitrequest;

    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          state_d   = S_WR;
          consume_s = 1'b1;
          wdata_d   = 32'(next_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_acc_s) begin
          count_d = next_q;
          next_d  = next_inc_s;
          if (VERIFY) begin
            state_d = S_RD;
          end else if (pend_q && enable) begin
            state_d   = S_WR;
            consume_s = 1'b1;
            wdata_d   = 32'(next_inc_s);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_RD: begin
        if (rd_acc_s) begin
          mism_s = (avm_readdata[COUNT_W-1:0] != count_q);
          // A tick that arrived during the transaction starts the next write directly.
          if (pend_q && enable) begin
            state_d   = S_WR;
            consume_s = 1'b1;
            wdata_d   = 32'(next_q);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable) begin
      pend_d = 1'b0;
    end else if (consume_s) begin
      pend_d = 1'b0;
    end else if (tick_s && (state_q != S_IDLE) && !pend_q) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    if (mism_s) begin
      error_d = 1'b1;
    end else if (err_clear) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end

    // A second tick while one is already waiting is dropped, never queued.
    if (tick_s && pend_q) begin
      overrun_d = 1'b1;
    end else if (err_clear) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    write_d = (state_d == S_WR);
    read_d  = (state_d == S_RD);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      next_q    <= '0;
      count_q   <= '0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      next_q    <= next_d;
      count_q   <= count_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  assign avm_address   = 2'(TARGET_ADDR);
  assign avm_write     = write_q;
  assign avm_read      = read_q;
  assign avm_writedata = wdata_q;
  assign count         = count_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_count_binary_led_writer.sv
// Self-checking bench for count_binary_led_writer: directed steps plus random stalls,
// corrupt readbacks and enable toggles, scored against a tick/count reference model.
module tb_count_binary_led_writer;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        err_clear;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [7:0]  count;
  logic        busy;
  logic        error;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [7:0] exp_next, exp_count, slave_mem;
  logic       exp_error, exp_overrun, wr_active;
  int         en_cnt, ticks_acc, wr_started, n_acc;
  int         tick_cyc[$];

  always #5 clk = ~clk;

  count_binary_led_writer #(
    .TICK_DIV(TDIV), .COUNT_W(8), .TARGET_ADDR(0), .VERIFY(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .err_clear(err_clear),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .count(count), .busy(busy),
    .error(error), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_next = 8'd0; exp_count = 8'd0; exp_error = 1'b0; exp_overrun = 1'b0;
    wr_active = 1'b0; en_cnt = 0; ticks_acc = 0; wr_started = 0; n_acc = 0;
    slave_mem = 8'd0;
  endtask

  // One clock cycle: drive slave response, advance the model, check after the edge.
  task automatic step(input bit stall, input bit ov_en, input logic [31:0] ov_val, input bit clr);
    logic [31:0] rnd;
    logic [7:0]  nxt_count;
    logic        nxt_err, nxt_ovr, drop, mism, tick_now;
    rnd = $urandom;
    avm_waitrequest = stall;
    err_clear       = clr;
    avm_readdata    = ov_en ? ov_val : {rnd[31:8], slave_mem};
    if (avm_write && !wr_active) begin
      wr_started++;
      chk("wr_budget", 32'(wr_started <= ticks_acc), 32'd1);
    end
    if (avm_write) begin
      chk("wdata", avm_writedata, {24'h0, exp_next});
      chk("addr", 32'(avm_address), 32'd0);
    end
    tick_now = enable && (en_cnt == TDIV - 1);
    drop = 1'b0;
    if (tick_now) begin
      tick_cyc.push_back(cyc);
      if (ticks_acc > wr_started) drop = 1'b1;
      else ticks_acc++;
    end
    if (!enable) ticks_acc = wr_started;
    en_cnt = enable ? (en_cnt + 1) % TDIV : 0;
    mism = avm_read && !stall && (avm_readdata[7:0] != exp_count);
    nxt_count = exp_count;
    if (avm_write && !stall) begin
      slave_mem = avm_writedata[7:0];
      nxt_count = exp_next;
      exp_next  = exp_next + 8'd1;
      n_acc++;
    end
    wr_active = avm_write && stall;
    nxt_err = mism ? 1'b1 : (clr ? 1'b0 : exp_error);
    nxt_ovr = drop ? 1'b1 : (clr ? 1'b0 : exp_overrun);
    @(posedge clk);
    exp_count = nxt_count; exp_error = nxt_err; exp_overrun = nxt_ovr;
    @(negedge clk);
    cyc++;
    err_clear = 1'b0;
    chk("count", 32'(count), 32'(exp_count));
    chk("error", 32'(error), 32'(exp_error));
    chk("overrun", 32'(overrun), 32'(exp_overrun));
    chk("wr_rd_excl", 32'(avm_write & avm_read), 32'd0);
  endtask

  task automatic run_until_wr(input logic [7:0] target, input int budget);
    int n;
    n = 0;
    while (!(avm_write && !wr_active && avm_writedata[7:0] == target) && n < budget) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      n++;
    end
    chk("wr_reached", 32'(avm_write && avm_writedata[7:0] == target), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int first_wr, n0, s0, guard;
    logic [7:0] c0;

    // 1: reset with random inputs
    r = $urandom;
    reset_n = 1'b0; enable = r[0]; err_clear = r[1]; avm_waitrequest = r[2];
    avm_readdata = $urandom;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      chk("rst_write", 32'(avm_write), 32'd0);
      chk("rst_read", 32'(avm_read), 32'd0);
      chk("rst_wdata", avm_writedata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'({error, overrun}), 32'd0);
    end
    reset_n = 1'b1; enable = 1'b1; err_clear = 1'b0; avm_waitrequest = 1'b0;

    // 2: writes every TDIV cycles, each followed by a read
    run_until_wr(8'h00, 20);
    chk("wr_latency", 32'(cyc - tick_cyc[$]), 32'd1);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_noread", 32'(avm_read), 32'd0);
    first_wr = cyc;
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("rd_follows", 32'({avm_write, avm_read}), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("idle_after_rd", 32'({avm_write, avm_read, busy}), 32'd0);
    run_until_wr(8'h01, 20);
    chk("wr_period1", 32'(cyc - first_wr), 32'(TDIV));
    run_until_wr(8'h02, 20);
    chk("wr_period2", 32'(cyc - first_wr), 32'(2 * TDIV));

    // 3: wrap after 257 accepts
    guard = 0;
    while (n_acc < 257 && guard < 3000) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      guard++;
    end
    chk("n257", 32'(n_acc), 32'd257);
    chk("count_wrap", 32'(count), 32'd0);

    // 4: stalled write of 0x05 holds stable and is accepted once
    run_until_wr(8'h05, 100);
    n0 = n_acc; s0 = wr_started;
    for (int i = 0; i < 4; i++) begin
      chk("hold_write", 32'(avm_write), 32'd1);
      chk("hold_addr", 32'(avm_address), 32'd0);
      chk("hold_wdata", avm_writedata, 32'h05);
      step(i < 3, 1'b0, 32'd0, 1'b0);
    end
    chk("one_accept", 32'(n_acc - n0), 32'd1);
    chk("one_start", 32'(wr_started - s0), 32'd1);
    chk("count_05", 32'(count), 32'h05);

    // 5: corrupt readback of 0x12
    run_until_wr(8'h12, 200);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("rd_of_12", 32'(avm_read), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0055, 1'b0);
    chk("err_set", 32'(error), 32'd1);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("err_hold", 32'(error), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("err_clr", 32'(error), 32'd0);

    // enable falls mid-write: transaction completes, then stays idle
    run_until_wr(exp_next, 20);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    enable = 1'b0;
    c0 = exp_next;
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("en_hold_wr", 32'(avm_write), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("en_rd", 32'(avm_read), 32'd1);
    s0 = wr_started;
    repeat (12) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("en_idle", 32'({avm_write, avm_read, busy}), 32'd0);
    chk("en_nostart", 32'(wr_started - s0), 32'd0);
    chk("en_count", 32'(count), 32'(c0));
    enable = 1'b1;

    // 6: long stall drops a tick; later writes stay consecutive
    run_until_wr(exp_next, 20);
    repeat (10) step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("overrun_set", 32'(overrun), 32'd1);
    c0 = count; n0 = n_acc; guard = 0;
    while (n_acc < n0 + 3 && guard < 100) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      guard++;
    end
    chk("consec_count", 32'(count), 32'(c0 + 8'd3));
    chk("overrun_hold", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("overrun_clr", 32'(overrun), 32'd0);

    // reset mid-write: outputs drop at once, next write restarts at 0x00
    run_until_wr(exp_next, 20);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_write", 32'(avm_write), 32'd0);
    chk("rst_mid_read", 32'(avm_read), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_until_wr(8'h00, 20);
    chk("post_rst_wdata", avm_writedata, 32'd0);

    // random stalls, corrupt readbacks, clears and enable toggles
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      if (r[29:24] == 6'd0) enable = ~enable;
      step(r[1:0] == 2'd0, r[7:4] == 4'd0, $urandom, r[12:8] == 5'd0);
    end
    enable = 1'b1;
    repeat (20) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("rand_progress", 32'(n_acc > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
